// File: rtl/coef_link_pkg.sv
// Shared definitions for the dct -> idct coefficient link.
//   BLK        coefficients per block (8x8, row-major)
//   IDX_W      width of a coefficient index within a block
//   rd_state_e replay FSM states
//   zone_keep  zonal mask: keep (r,c) iff r + c <= lim
package coef_link_pkg;

  localparam int unsigned BLK   = 64;
  localparam int unsigned IDX_W = 6;

  typedef enum logic [1:0] {StIdle, StSend, StGap} rd_state_e;

  function automatic logic zone_keep(input logic [IDX_W-1:0] idx, input logic [3:0] lim);
    logic [3:0] sum;
    sum = {1'b0, idx[5:3]} + {1'b0, idx[2:0]};
    return sum <= lim;
  endfunction

endpackage

// File: rtl/coef_link_if.sv
// Stream bundle between dct, coef_link and idct.
//   in_valid/in_data/zone_lim/sat_en  dct side, one coefficient per cycle
//   out_start/out_data/out_ready      idct side, consumed while start & ready
// master: the environment (dct producer + idct consumer); slave: coef_link.
interface coef_link_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic [3:0]       zone_lim;
  logic             sat_en;
  logic             out_start;
  logic [OUT_W-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, zone_lim, sat_en, out_ready,
    input  out_start, out_data
  );

  modport slave (
    input  in_valid, in_data, zone_lim, sat_en, out_ready,
    output out_start, out_data
  );
endinterface

// File: rtl/coef_scale.sv
// Combinational per-coefficient conditioning.
//   in_data   signed dct coefficient (IN_W)
//   sat_en    1 = clamp to signed COEF_W, 0 = keep low COEF_W bits
//   keep      zonal mask decision; 0 forces the result to zero
//   out_data  result sign-extended to OUT_W
//   clip      a clamp took place (only possible with sat_en=1)
module coef_scale #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned SHIFT  = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 32
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  input  logic             keep,
  output logic [OUT_W-1:0] out_data,
  output logic             clip
);

  localparam logic signed [IN_W-1:0] CoefMax = IN_W'((64'sd1 <<< (COEF_W - 1)) - 64'sd1);
  localparam logic signed [IN_W-1:0] CoefMin = ~CoefMax;

  logic signed [IN_W-1:0] shifted;
  logic [COEF_W-1:0]      coef;

  always_comb begin
    shifted = $signed(in_data) >>> SHIFT;
    clip    = 1'b0;
    coef    = shifted[COEF_W-1:0];
    if (sat_en) begin
      if (shifted > CoefMax) begin
        coef = CoefMax[COEF_W-1:0];
        clip = 1'b1;
      end else if (shifted < CoefMin) begin
        coef = CoefMin[COEF_W-1:0];
        clip = 1'b1;
      end
    end
    out_data = keep ? {{(OUT_W - COEF_W){coef[COEF_W-1]}}, coef} : '0;
  end

endmodule

// File: rtl/coef_link.sv
// Decoupling link between dct and idct: scales/saturates/masks each incoming
// 64-coefficient block into a ping-pong buffer and replays full banks to the
// idct with a start/ready handshake.
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   link      coef_link_if slave (dct stream in, idct stream out)
//   busy      a bank is full or a block write is in progress
//   blk_cnt   blocks delivered to the idct (wraps)
//   sat_cnt   coefficients clipped (sticks at all-ones)
//   err_drop  sticky: a block was dropped or truncated
module coef_link
  import coef_link_pkg::*;
#(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned SHIFT  = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  coef_link_if.slave       link,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             err_drop
);

  logic [OUT_W-1:0] mem_q [2][BLK];

  // Write side
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             drop_q, drop_d;
  logic [3:0]       zone_q, zone_d, zone_eff;
  logic [1:0]       full_q, full_d, full_set, full_clr;
  logic             err_q, err_d;
  logic             wr_en;
  logic [OUT_W-1:0] scaled;
  logic             clip;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  // Read side
  rd_state_e        state_q, state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d, rd_nxt;
  logic             rd_bank_q, rd_bank_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  // zone_lim is taken live on the first coefficient of a block, latched after.
  assign zone_eff = (wr_idx_q == '0) ? link.zone_lim : zone_q;

  coef_scale #(
    .IN_W   (IN_W),
    .SHIFT  (SHIFT),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_scale (
    .in_data  (link.in_data),
    .sat_en   (link.sat_en),
    .keep     (zone_keep(wr_idx_q, zone_eff)),
    .out_data (scaled),
    .clip     (clip)
  );

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    drop_d    = drop_q;
    zone_d    = zone_q;
    full_set  = '0;
    err_d     = err_q;
    wr_en     = 1'b0;
    sat_cnt_d = sat_cnt_q;
    if (link.in_valid) begin
      if (drop_q) begin
        // rest of a rejected burst: discard
      end else if ((wr_idx_q == '0) && full_q[wr_bank_q]) begin
        drop_d = 1'b1;
        err_d  = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (clip && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + 1'b1;
        if (wr_idx_q == '0) zone_d = link.zone_lim;
        if (wr_idx_q == IDX_W'(BLK - 1)) begin
          full_set[wr_bank_q] = 1'b1;
          wr_bank_d           = ~wr_bank_q;
          wr_idx_d            = '0;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
    end else begin
      drop_d = 1'b0;
      // burst ended mid-block: abandon it, bank stays empty
      if (wr_idx_q != '0) begin
        wr_idx_d = '0;
        err_d    = 1'b1;
      end
    end
  end

  assign rd_nxt = rd_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    rd_bank_d  = rd_bank_q;
    out_data_d = out_data_q;
    blk_cnt_d  = blk_cnt_q;
    full_clr   = '0;
    case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d    = StSend;
          out_data_d = mem_q[rd_bank_q][0];
        end
      end
      StSend: begin
        if (link.out_ready) begin
          if (rd_idx_q == IDX_W'(BLK - 1)) begin
            full_clr[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            blk_cnt_d           = blk_cnt_q + 1'b1;
            rd_idx_d            = '0;
            out_data_d          = '0;
            state_d             = StGap;
          end else begin
            rd_idx_d   = rd_nxt;
            out_data_d = mem_q[rd_bank_q][rd_nxt];
          end
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Set and clear never hit the same bank in one cycle.
  assign full_d = (full_q & ~full_clr) | full_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      drop_q     <= 1'b0;
      zone_q     <= '0;
      full_q     <= '0;
      err_q      <= 1'b0;
      sat_cnt_q  <= '0;
      state_q    <= StIdle;
      rd_idx_q   <= '0;
      rd_bank_q  <= 1'b0;
      out_data_q <= '0;
      blk_cnt_q  <= '0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      wr_bank_q  <= wr_bank_d;
      drop_q     <= drop_d;
      zone_q     <= zone_d;
      full_q     <= full_d;
      err_q      <= err_d;
      sat_cnt_q  <= sat_cnt_d;
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      rd_bank_q  <= rd_bank_d;
      out_data_q <= out_data_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  // Buffer contents need no reset; the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank_q][wr_idx_q] <= scaled;
  end

  assign link.out_start = (state_q == StSend);
  assign link.out_data  = out_data_q;
  assign busy           = full_q[0] | full_q[1] | (wr_idx_q != '0);
  assign blk_cnt        = blk_cnt_q;
  assign sat_cnt        = sat_cnt_q;
  assign err_drop       = err_q;

endmodule

// File: doc/coef_link.md
Name: coef_link

Overview:
- Parametrised inter-stage link between the dct and idct blocks; replaces the fixed top-level slice-and-sign-extend of dct output.
- Captures each 64-coefficient block on the dct done burst and applies an arithmetic right shift, signed saturation and a runtime zonal (approximation) mask.
- Stores results in a ping-pong buffer and replays each block to the idct with a start/reading handshake.
- Lets dct and idct run decoupled, and allows approximation level to change per block.

Parameters:
IN_W, 32, dct output width (signed)
SHIFT, 16, arithmetic right shift applied to each coefficient
COEF_W, 16, signed saturation width after shift
OUT_W, 32, idct input width; saturated value sign-extended to this
CNT_W, 16, width of block and saturation counters

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  dct done; high for one coefficient per cycle
in_data  in  IN_W  dct coefficient, row-major order
zone_lim  in  4  keep coefficient (r,c) iff r+c <= zone_lim; sampled at block start
sat_en  in  1  1 = saturate to COEF_W, 0 = wrap (truncate)
out_start  out  1  drives idct start
out_data  out  OUT_W  coefficient to idct
out_ready  in  1  idct reading; data consumed in any cycle it is high while out_start high
busy  out  1  any bank full or write in progress
blk_cnt  out  CNT_W  blocks delivered to idct, wraps
sat_cnt  out  CNT_W  coefficients clipped, saturates at all-ones
err_drop  out  1  sticky: block dropped or truncated

Behaviour:
- Reset (reset=0, async): all outputs 0, both banks empty, wr_idx=rd_idx=0, wr_bank=rd_bank=0, FSM IDLE. Buffer contents are don't-care.
- Scale: s = in_data >>> SHIFT (sign-preserving).
  - sat_en=1: clamp to [-2^(COEF_W-1), 2^(COEF_W-1)-1]; increment sat_cnt on each clamp.
  - sat_en=0: keep low COEF_W bits.
  - Result is sign-extended to OUT_W.
- Mask: k=wr_idx, r=k[5:3], c=k[2:0]. Stored value is 0 when r+c > zone_lim_latched. zone_lim=14 or 15 keeps all 64.
- Write side:
  - Each cycle with in_valid=1, write bank[wr_bank][wr_idx] and increment wr_idx.
  - zone_lim is latched on the cycle wr_idx==0.
  - At wr_idx==63: mark the bank full, toggle wr_bank, set wr_idx=0.
  - Write starts only if bank[wr_bank] is empty. Otherwise the whole incoming burst (until in_valid falls) is discarded and err_drop is set.
  - in_valid falling with 0<wr_idx<64: partial block discarded, wr_idx=0, err_drop set, bank stays empty.
  - A burst longer than 64 starts a new block in the other bank at the 65th coefficient.
- Read FSM states:
  - IDLE: if bank[rd_bank] full, go to SEND next cycle (first out_start one cycle after the full flag sets).
  - SEND: out_start=1, out_data=bank[rd_bank][rd_idx] (registered). On out_ready=1, rd_idx advances.
    - On consuming idx 63: clear bank full, toggle rd_bank, increment blk_cnt, rd_idx=0, go to GAP.
    - out_ready=0 stalls with out_data held.
  - GAP: out_start=0 for exactly one cycle, then IDLE. Guarantees the idct sees a start edge.
- A write into one bank and a free of the other bank in the same cycle are both honoured.
- Full-set and clear never target the same bank in the same cycle.
- busy = full[0] | full[1] | (wr_idx != 0).
- Reset mid-block aborts both sides immediately; no partial output is replayed after reset release.

Decomposition:
- Package coef_link_pkg: BLK=64, IDX_W=6, FSM state enum {IDLE, SEND, GAP}, function zone_keep(idx, lim).
- Sub-module coef_scale: combinational shift/saturate/mask with a clip flag output, parametrised by IN_W, SHIFT, COEF_W, OUT_W.
- Buffer is two 64xOUT_W arrays inside coef_link.

Test Plan:
- One block, in_data=k<<16 for k=0..63, zone_lim=14, out_ready=1 -> out_start rises 1 cycle after last write; out_data=0..63 in order; blk_cnt=1; then a 1-cycle gap.
- Same block with zone_lim=3 -> only the 10 positions with r+c<=3 are nonzero (idx 0,1,2,3,8,9,10,16,17,24); others are 0.
- in_data=32'h7FFF_0000+... and 32'h8000_0000, sat_en=1, COEF_W=12 -> outputs 2047 / -2048 sign-extended; sat_cnt increments per clip. Same stimulus with sat_en=0 -> low 12 bits, sat_cnt unchanged.
- Three back-to-back blocks with out_ready=0 -> blocks 1 and 2 buffered, block 3 dropped, err_drop=1. Releasing out_ready delivers blocks 1 and 2 intact; blk_cnt=2.
- in_valid held 30 cycles only -> no out_start, err_drop=1. A following full block is delivered correctly.
- reset pulled low at rd_idx=20 -> out_start=0 and all counters 0 asynchronously; after release, a fresh block is delivered from idx 0.
